// File: rtl/noc_credit_tx_if.sv
// Credit-based flit link: client valid/ready side plus router send/credit side.
interface noc_credit_tx_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int DEST_WIDTH = 1
);
   logic                  in_valid;
   logic                  in_ready;
   logic [FLIT_WIDTH-1:0] in_data;
   logic [DEST_WIDTH-1:0] in_dest;
   logic                  in_is_tail;
   logic                  send_out;
   logic [FLIT_WIDTH-1:0] data_out;
   logic [DEST_WIDTH-1:0] dest_out;
   logic                  is_tail_out;
   logic                  credit_in;

   // Transmitter view: consumes client flits and credits, drives the router link.
   modport master (
      input  in_valid, in_data, in_dest, in_is_tail, credit_in,
      output in_ready, send_out, data_out, dest_out, is_tail_out
   );

   // Environment view: client source plus router receive port.
   modport slave (
      output in_valid, in_data, in_dest, in_is_tail, credit_in,
      input  in_ready, send_out, data_out, dest_out, is_tail_out
   );
endinterface

// File: rtl/noc_credit_tx.sv
// Endpoint flit injector: queues client flits and launches them to a router
// input port only while a downstream buffer credit is held.
module noc_credit_tx #(
   parameter int FLIT_WIDTH   = 32,
   parameter int DEST_WIDTH   = 1,
   parameter int CREDIT_DEPTH = 4,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   noc_credit_tx_if.master                    bus,
   output logic [$clog2(CREDIT_DEPTH+1)-1:0]  credit_count,
   output logic                               credit_err
);
   localparam int CW = $clog2(CREDIT_DEPTH + 1);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int OW = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_DEPTH);
   localparam logic [OW-1:0] QUEUE_FULL = OW'(QUEUE_DEPTH);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  tail;
   } flit_t;

   typedef enum logic {HEAD, BODY} in_state_t;

   in_state_t             state, state_next;
   logic [DEST_WIDTH-1:0] dest_latch, dest_latch_next, enq_dest;

   flit_t                 mem [QUEUE_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         occupancy;
   logic                  accept, launch;

   // Ready depends on occupancy only, so a pop on a full queue frees space one cycle later.
   assign bus.in_ready = rst_n && (occupancy != QUEUE_FULL);
   assign accept       = bus.in_valid && bus.in_ready;
   // Uses the registered credit count: a credit arriving this cycle is not yet spendable.
   assign launch       = (occupancy != '0) && (credit_count != '0);

   // Input packet FSM state and head-flit destination latch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= HEAD;
         dest_latch <= '0;
      end else begin
         state      <= state_next;
         dest_latch <= dest_latch_next;
      end
   end

   // Head flits carry their own dest; body/tail flits reuse the latched head dest.
   always_comb begin
      state_next      = state;
      dest_latch_next = dest_latch;
      enq_dest        = dest_latch;
      case (state)
         HEAD: begin
            enq_dest = bus.in_dest;
            if (accept) begin
               dest_latch_next = bus.in_dest;
               if (!bus.in_is_tail) state_next = BODY;
            end
         end
         BODY: begin
            if (accept && bus.in_is_tail) state_next = HEAD;
         end
         default: state_next = HEAD;
      endcase
   end

   // Queue storage write; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= '{data: bus.in_data, dest: enq_dest, tail: bus.in_is_tail};
   end

   // Queue pointers wrap naturally; occupancy has QUEUE_DEPTH+1 states.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (launch) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, launch})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Registered launch onto the router link; payload holds between launches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.send_out    <= 1'b0;
         bus.data_out    <= '0;
         bus.dest_out    <= '0;
         bus.is_tail_out <= 1'b0;
      end else begin
         bus.send_out <= launch;
         if (launch) begin
            bus.data_out    <= mem[rd_ptr].data;
            bus.dest_out    <= mem[rd_ptr].dest;
            bus.is_tail_out <= mem[rd_ptr].tail;
         end
      end
   end

   // Credit counter: spend on launch, refill on credit_in, saturate with sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_count <= CREDIT_MAX;
         credit_err   <= 1'b0;
      end else begin
         case ({launch, bus.credit_in})
            2'b10: credit_count <= credit_count - 1'b1;
            2'b01: begin
               if (credit_count == CREDIT_MAX) credit_err <= 1'b1;
               else                            credit_count <= credit_count + 1'b1;
            end
            default: credit_count <= credit_count;
         endcase
      end
   end
endmodule

// File: tb/tb_noc_credit_tx.sv
// Scoreboard bench for noc_credit_tx: a queue/counter reference model predicts
// flits and credit state; a monitor compares on every falling edge.
module tb_noc_credit_tx;
   localparam int FW = 32;
   localparam int DW = 1;
   localparam int CD = 4;
   localparam int QD = 4;
   localparam int CW = $clog2(CD + 1);

   typedef struct packed {
      logic [FW-1:0] data;
      logic [DW-1:0] dest;
      logic          tail;
   } flit_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] credit_count;
   logic          credit_err;

   noc_credit_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) bus ();

   noc_credit_tx #(
      .FLIT_WIDTH  (FW),
      .DEST_WIDTH  (DW),
      .CREDIT_DEPTH(CD),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .credit_count(credit_count),
      .credit_err  (credit_err)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   int            n_sent = 0;
   flit_t         expq[$];
   flit_t         last_m;
   flit_t         mon_e;
   flit_t         mdl_f;
   int            pend_m;
   int            cred_m;
   bit            err_m, launch_m, acc_ev, in_pkt_m;
   bit            mon_en = 1'b0;
   logic [DW-1:0] pkt_dest_m;
   int            cmode = 0;
   int            min_cred;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: packet-level dest rule, pending-flit count, credit arithmetic.
   initial forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
         expq.delete();
         pend_m   = 0;
         cred_m   = CD;
         err_m    = 1'b0;
         in_pkt_m = 1'b0;
         launch_m = 1'b0;
         acc_ev   = 1'b0;
      end else begin
         launch_m = (pend_m > 0) && (cred_m > 0);
         acc_ev   = (bus.in_valid === 1'b1) && (pend_m < QD);
         if (launch_m) pend_m--;
         if (launch_m && !bus.credit_in) cred_m--;
         else if (!launch_m && bus.credit_in) begin
            if (cred_m == CD) err_m = 1'b1;
            else              cred_m++;
         end
         if (acc_ev) begin
            if (!in_pkt_m) pkt_dest_m = bus.in_dest;
            mdl_f.data = bus.in_data;
            mdl_f.dest = pkt_dest_m;
            mdl_f.tail = bus.in_is_tail;
            expq.push_back(mdl_f);
            pend_m++;
            in_pkt_m = !bus.in_is_tail;
         end
      end
   end

   // Monitor: compares link outputs and status against the model each falling edge.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("send_out", 64'(bus.send_out), 64'(launch_m));
         chk("credit_count", 64'(credit_count), 64'(cred_m));
         chk("credit_err", 64'(credit_err), 64'(err_m));
         chk("in_ready", 64'(bus.in_ready), 64'((rst_n === 1'b1) && (pend_m < QD)));
         if (bus.send_out === 1'b1) begin
            n_sent++;
            if (expq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_flit: got data %0h expected no flit (t=%0t)", bus.data_out, $time);
            end else begin
               mon_e = expq.pop_front();
               chk("data_out", 64'(bus.data_out), 64'(mon_e.data));
               chk("dest_out", 64'(bus.dest_out), 64'(mon_e.dest));
               chk("is_tail_out", 64'(bus.is_tail_out), 64'(mon_e.tail));
               last_m = mon_e;
            end
         end else begin
            chk("data_hold", 64'(bus.data_out), 64'(last_m.data));
            chk("dest_hold", 64'(bus.dest_out), 64'(last_m.dest));
            chk("tail_hold", 64'(bus.is_tail_out), 64'(last_m.tail));
         end
         if (rst_n !== 1'b1) last_m = '0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (cmode)
         1:       bus.credit_in = bus.send_out;
         2:       bus.credit_in = (cred_m < CD) && ($urandom_range(0, 2) != 0);
         default: bus.credit_in = 1'b0;
      endcase
      if (cmode == 1 && int'(credit_count) < min_cred) min_cred = int'(credit_count);
   endtask

   task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic tl);
      int unsigned guard;
      guard          = 0;
      bus.in_valid   = 1'b1;
      bus.in_data    = d;
      bus.in_dest    = dst;
      bus.in_is_tail = tl;
      do begin
         tick();
         guard++;
      end while (!acc_ev && guard < 200);
      if (!acc_ev) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: flit %0h not accepted after %0d cycles", d, guard);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      cmode = 0;
      while ((pend_m != 0 || cred_m != CD) && guard < 200) begin
         bus.credit_in = (cred_m < CD);
         tick();
         guard++;
      end
      if (guard >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: pending %0d credits %0d required 0 and %0d", pend_m, cred_m, CD);
      end
      bus.credit_in = 1'b0;
      tick();
      tick();
   endtask

   // Watchdog against a stalled run.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

   // Stimulus sequence.
   initial begin
      int s0;
      int k_ready;
      int plen;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_dest    = '0;
      bus.in_is_tail = 1'b0;
      bus.credit_in  = 1'b0;
      min_cred       = CD;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_credit_count", 64'(credit_count), 64'(CD));
      chk("rst_send_out", 64'(bus.send_out), 64'(0));
      chk("rst_data_out", 64'(bus.data_out), 64'(0));
      chk("rst_credit_err", 64'(credit_err), 64'(0));
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

      // Loopback credits, 8 single-flit packets
      cmode    = 1;
      min_cred = CD;
      for (int i = 1; i <= 8; i++) send_flit(FW'(i), DW'((i - 1) % 2), 1'b1);
      repeat (4) tick();
      chk("loop_min_credit", 64'(min_cred), 64'(3));
      drain();

      // No credits returned: 4 sends, then queue fills
      s0 = n_sent;
      for (int i = 1; i <= 8; i++) send_flit(FW'(32'h200 + i), '0, 1'b1);
      tick();
      tick();
      chk("nocred_sends", 64'(n_sent - s0), 64'(4));
      chk("nocred_count", 64'(credit_count), 64'(0));
      chk("nocred_full", 64'(bus.in_ready), 64'(0));
      s0 = n_sent;
      bus.credit_in = 1'b1;
      tick();
      chk("credit_not_same_cycle", 64'(bus.send_out), 64'(0));
      chk("credit_registered", 64'(credit_count), 64'(1));
      bus.credit_in = 1'b1;
      tick();
      chk("credit_first_send", 64'(bus.send_out), 64'(1));
      chk("credit_first_data", 64'(bus.data_out), 64'(32'h205));
      repeat (4) tick();
      chk("credit_two_sends", 64'(n_sent - s0), 64'(2));
      drain();

      // Multi-flit packet then single-flit packet
      cmode = 1;
      send_flit(32'h301, 1'b1, 1'b0);
      send_flit(32'h302, 1'b0, 1'b0);
      send_flit(32'h303, 1'b0, 1'b0);
      send_flit(32'h304, 1'b0, 1'b1);
      send_flit(32'h305, 1'b0, 1'b1);
      repeat (4) tick();
      drain();

      // Simultaneous launch and credit at count 2
      send_flit(32'h401, 1'b0, 1'b1);
      send_flit(32'h402, 1'b1, 1'b1);
      repeat (3) tick();
      chk("simul_pre_count", 64'(credit_count), 64'(2));
      send_flit(32'h403, 1'b1, 1'b1);
      bus.credit_in = 1'b1;
      tick();
      chk("simul_send", 64'(bus.send_out), 64'(1));
      chk("simul_count", 64'(credit_count), 64'(2));
      drain();

      // Spurious credit at full count
      bus.credit_in = 1'b1;
      tick();
      chk("spurious_err", 64'(credit_err), 64'(1));
      chk("spurious_count", 64'(credit_count), 64'(CD));
      repeat (3) tick();
      chk("spurious_err_sticky", 64'(credit_err), 64'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("err_cleared", 64'(credit_err), 64'(0));

      // Reset mid-packet with 3 flits queued and count 1
      for (int i = 1; i <= 4; i++) send_flit(FW'(32'h500 + i), '0, 1'b1);
      send_flit(32'h511, 1'b1, 1'b0);
      send_flit(32'h512, 1'b0, 1'b0);
      send_flit(32'h513, 1'b0, 1'b0);
      tick();
      bus.credit_in = 1'b1;
      tick();
      chk("midpkt_count", 64'(credit_count), 64'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("midpkt_send_out", 64'(bus.send_out), 64'(0));
      chk("midpkt_credit", 64'(credit_count), 64'(CD));
      chk("midpkt_in_ready", 64'(bus.in_ready), 64'(1));
      s0 = n_sent;
      repeat (4) tick();
      chk("midpkt_no_stale", 64'(n_sent - s0), 64'(0));
      send_flit(32'h521, 1'b0, 1'b1);
      repeat (3) tick();
      chk("midpkt_new_head_dest", 64'(bus.dest_out), 64'(0));
      drain();

      // Full queue with credit arriving: pop per cycle, ready one cycle later
      for (int i = 1; i <= 8; i++) send_flit(FW'(32'h600 + i), DW'(i % 2), 1'b1);
      tick();
      chk("full_ready_low", 64'(bus.in_ready), 64'(0));
      bus.in_valid   = 1'b1;
      bus.in_data    = 32'h6FF;
      bus.in_dest    = 1'b1;
      bus.in_is_tail = 1'b1;
      bus.credit_in  = 1'b1;
      k_ready        = -1;
      for (int k = 0; k < 8; k++) begin
         tick();
         bus.credit_in = (k < 3);
         if (k_ready < 0 && bus.in_ready === 1'b1) k_ready = k;
         if (acc_ev) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("full_pop_ready_rise", 64'(k_ready), 64'(1));
      drain();

      // Randomized packets with random credit return
      cmode = 2;
      plen  = 0;
      for (int n = 0; n < 300; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         if (plen == 0) plen = $urandom_range(1, 4);
         plen--;
         send_flit(FW'($urandom()), DW'($urandom_range(0, 1)), (plen == 0));
      end
      drain();

      chk("scoreboard_empty", 64'(expq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
